// File: rtl/manchester_link_ctrl.sv
// Manchester line-sync controller: hunts half-bit phase by slipping on invalid
// pairs, holds lock, and drives converter enable/sync plus NRZ and PAM4 strobes.
module manchester_link_ctrl #(
  parameter int LOCK_PAIRS = 8,
  parameter int LOSS_PAIRS = 3,
  parameter int ERR_W      = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             manchester_in,
  input  logic             err_clr,
  output logic             locked,
  output logic             conv_enable,
  output logic             dp_sync,
  output logic             half_phase,
  output logic             nrz_strobe,
  output logic             pam_strobe,
  output logic             code_err,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic {ST_HUNT = 1'b0, ST_LOCKED = 1'b1} state_t;

  localparam logic [7:0]       LOCK_TH = 8'(LOCK_PAIRS);
  localparam logic [7:0]       LOSS_TH = 8'(LOSS_PAIRS);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  state_t           state_q, state_d;
  logic             half_q, half_d;
  logic             prev_q, prev_d;
  logic [7:0]       good_cnt_q, good_cnt_d;
  logic [7:0]       bad_run_q, bad_run_d;
  logic             sym_q, sym_d;
  logic             dp_sync_q, dp_sync_d;
  logic             nrz_strobe_q, nrz_strobe_d;
  logic             pam_strobe_q, pam_strobe_d;
  logic             code_err_q, code_err_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  logic       pair_valid;
  logic [7:0] good_inc, bad_inc;

  assign pair_valid = prev_q ^ manchester_in;
  assign good_inc   = (good_cnt_q == 8'hFF) ? good_cnt_q : good_cnt_q + 8'd1;
  assign bad_inc    = (bad_run_q == 8'hFF) ? bad_run_q : bad_run_q + 8'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_HUNT;
      half_q       <= 1'b0;
      prev_q       <= 1'b0;
      good_cnt_q   <= 8'd0;
      bad_run_q    <= 8'd0;
      sym_q        <= 1'b0;
      dp_sync_q    <= 1'b0;
      nrz_strobe_q <= 1'b0;
      pam_strobe_q <= 1'b0;
      code_err_q   <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      half_q       <= half_d;
      prev_q       <= prev_d;
      good_cnt_q   <= good_cnt_d;
      bad_run_q    <= bad_run_d;
      sym_q        <= sym_d;
      dp_sync_q    <= dp_sync_d;
      nrz_strobe_q <= nrz_strobe_d;
      pam_strobe_q <= pam_strobe_d;
      code_err_q   <= code_err_d;
      err_count_q  <= err_count_d;
    end
  end

  // Next-state: phase tracking, lock/loss decisions.
  always_comb begin
    state_d    = state_q;
    half_d     = half_q;
    prev_d     = prev_q;
    good_cnt_d = good_cnt_q;
    bad_run_d  = bad_run_q;
    sym_d      = sym_q;
    if (!half_q) begin
      prev_d = manchester_in;
      half_d = 1'b1;
    end else if (state_q == ST_HUNT) begin
      if (pair_valid) begin
        good_cnt_d = good_inc;
        half_d     = 1'b0;
        if (good_inc >= LOCK_TH) begin
          state_d   = ST_LOCKED;
          sym_d     = 1'b0;
          bad_run_d = 8'd0;
        end
      end else begin
        // Slip: the current sample becomes the first half of a new pair.
        prev_d     = manchester_in;
        good_cnt_d = 8'd0;
      end
    end else begin
      half_d = 1'b0;
      sym_d  = ~sym_q;
      if (pair_valid) begin
        bad_run_d = 8'd0;
      end else begin
        bad_run_d = bad_inc;
        if (bad_inc >= LOSS_TH) begin
          state_d    = ST_HUNT;
          good_cnt_d = 8'd0;
        end
      end
    end
  end

  // Registered outputs: pulses and the violation counter.
  always_comb begin
    dp_sync_d    = 1'b0;
    nrz_strobe_d = 1'b0;
    pam_strobe_d = 1'b0;
    code_err_d   = 1'b0;
    err_count_d  = err_count_q;
    if (half_q && state_q == ST_HUNT && pair_valid && good_inc >= LOCK_TH) begin
      dp_sync_d = 1'b1;
    end
    if (half_q && state_q == ST_LOCKED) begin
      nrz_strobe_d = 1'b1;
      pam_strobe_d = sym_q;
      if (!pair_valid) begin
        code_err_d = 1'b1;
        if (err_count_q != ERR_MAX) err_count_d = err_count_q + ERR_W'(1);
      end
    end
    if (err_clr) err_count_d = '0;
  end

  assign locked      = (state_q == ST_LOCKED);
  assign conv_enable = (state_q == ST_LOCKED);
  assign dp_sync     = dp_sync_q;
  assign half_phase  = half_q;
  assign nrz_strobe  = nrz_strobe_q;
  assign pam_strobe  = pam_strobe_q;
  assign code_err    = code_err_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_manchester_link_ctrl.sv
// Bench for manchester_link_ctrl: two instances (ERR_W=8 and ERR_W=2) share one
// sample stream and are checked every cycle against a sample-level model.
module tb_manchester_link_ctrl;

  localparam int W = 17;

  logic       clock;
  logic       reset;
  logic       manchester_in;
  logic       err_clr;
  logic       locked, conv_enable, dp_sync, half_phase;
  logic       nrz_strobe, pam_strobe, code_err;
  logic [7:0] err_count;
  logic       s_locked, s_conv_enable, s_dp_sync, s_half_phase;
  logic       s_nrz_strobe, s_pam_strobe, s_code_err;
  logic [1:0] s_err_count;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  // Model state: a buffered first-half sample (-1 when none), plain counters.
  int m_first, m_good, m_bad, m_nsym, m_err8, m_err2;
  bit m_locked, o_dp, o_nrz, o_pam, o_code;

  manchester_link_ctrl dut (
    .clock(clock), .reset(reset), .manchester_in(manchester_in), .err_clr(err_clr),
    .locked(locked), .conv_enable(conv_enable), .dp_sync(dp_sync),
    .half_phase(half_phase), .nrz_strobe(nrz_strobe), .pam_strobe(pam_strobe),
    .code_err(code_err), .err_count(err_count)
  );

  manchester_link_ctrl #(.ERR_W(2)) dut_sat (
    .clock(clock), .reset(reset), .manchester_in(manchester_in), .err_clr(err_clr),
    .locked(s_locked), .conv_enable(s_conv_enable), .dp_sync(s_dp_sync),
    .half_phase(s_half_phase), .nrz_strobe(s_nrz_strobe), .pam_strobe(s_pam_strobe),
    .code_err(s_code_err), .err_count(s_err_count)
  );

  // Clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [W-1:0] actual_vec();
    return {locked, conv_enable, dp_sync, half_phase, nrz_strobe, pam_strobe,
            code_err, err_count, s_err_count};
  endfunction

  function automatic logic [W-1:0] model_vec();
    logic [7:0] e8;
    logic [1:0] e2;
    e8 = 8'(m_err8);
    e2 = 2'(m_err2);
    return {m_locked, m_locked, o_dp, (m_first >= 0), o_nrz, o_pam, o_code, e8, e2};
  endfunction

  function automatic void check_vec(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s t=%0t got lk/en/sync/half/nrz/pam/cerr=%b err8=%0d err2=%0d want %b err8=%0d err2=%0d",
                 name, $time, act[16:10], act[9:2], act[1:0], exp[16:10], exp[9:2], exp[1:0]);
    end
  endfunction

  // Model of one clock edge, straight from the link rules.
  function automatic void model_step(bit din, bit clr, bit rst);
    o_dp = 0; o_nrz = 0; o_pam = 0; o_code = 0;
    if (rst) begin
      m_first = -1; m_good = 0; m_bad = 0; m_nsym = 0;
      m_err8 = 0; m_err2 = 0; m_locked = 0;
      return;
    end
    if (m_first < 0) begin
      m_first = din;
    end else begin
      bit valid;
      valid = (m_first != int'(din));
      if (!m_locked) begin
        if (valid) begin
          m_good = (m_good < 255) ? m_good + 1 : 255;
          m_first = -1;
          if (m_good >= 8) begin
            m_locked = 1; o_dp = 1; m_nsym = 0; m_bad = 0;
          end
        end else begin
          m_first = din;
          m_good = 0;
        end
      end else begin
        m_first = -1;
        o_nrz = 1;
        o_pam = (m_nsym % 2) == 1;
        m_nsym++;
        if (valid) begin
          m_bad = 0;
        end else begin
          o_code = 1;
          if (m_err8 < 255) m_err8++;
          if (m_err2 < 3) m_err2++;
          m_bad = (m_bad < 255) ? m_bad + 1 : 255;
          if (m_bad >= 3) begin
            m_locked = 0; m_good = 0;
          end
        end
      end
    end
    if (clr) begin
      m_err8 = 0; m_err2 = 0;
    end
  endfunction

  // Driver tasks
  task automatic drive(input bit din, input bit clr, input bit rst);
    @(negedge clock);
    manchester_in = din;
    err_clr = clr;
    reset = rst;
    model_step(din, clr, rst);
    exp_q.push_back(model_vec());
  endtask

  task automatic send_pair(input bit a, input bit b, input bit clr_second);
    drive(a, 1'b0, 1'b0);
    drive(b, clr_second, 1'b0);
  endtask

  task automatic send_valid(input int n);
    for (int i = 0; i < n; i++) begin
      bit d;
      d = bit'($urandom_range(0, 1));
      send_pair(d, ~d, 1'b0);
    end
  endtask

  task automatic hold_reset(input int n);
    for (int i = 0; i < n; i++) drive(i[0], 1'b0, 1'b1);
  endtask

  task automatic mid_reset();
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check_vec("async_reset", actual_vec(), '0);
    model_step(1'b0, 1'b0, 1'b1);
    hold_reset(2);
  endtask

  // Scoreboard monitor
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) check_vec("cycle", actual_vec(), exp_q.pop_front());
    end
  end

  initial begin
    reset = 1'b1;
    manchester_in = 1'b0;
    err_clr = 1'b0;
    model_step(1'b0, 1'b0, 1'b1);

    hold_reset(6);

    // Aligned lock with 10/01 pairs, then steady lock.
    for (int i = 0; i < 8; i++) send_pair(~i[0], i[0], 1'b0);
    send_valid(10);

    // Misaligned start: 0,0 then 10 pairs.
    hold_reset(2);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_pair(1'b1, 1'b0, 1'b0);
    send_valid(6);

    // Single violation in lock.
    send_pair(1'b1, 1'b1, 1'b0);
    send_valid(6);

    // Loss of lock and relock.
    for (int i = 0; i < 3; i++) send_pair(1'b0, 1'b0, 1'b0);
    send_valid(12);

    // Saturation on the narrow counter, then clear coinciding with a violation.
    for (int i = 0; i < 6; i++) begin
      send_pair(1'b0, 1'b0, 1'b0);
      send_valid(1);
    end
    send_pair(1'b1, 1'b1, 1'b1);
    send_valid(3);
    send_pair(1'b0, 1'b0, 1'b0);
    send_valid(2);
    mid_reset();

    // Random traffic: mostly valid pairs, some violations, stray samples, clears.
    for (int i = 0; i < 900; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 5) begin
        drive(bit'($urandom_range(0, 1)), 1'b0, 1'b0);
      end else if (r < 14) begin
        bit v;
        v = bit'($urandom_range(0, 1));
        send_pair(v, v, 1'b0);
      end else if (r < 17) begin
        send_pair(1'b1, 1'b1, bit'($urandom_range(0, 1)));
      end else begin
        bit d;
        d = bit'($urandom_range(0, 1));
        drive(d, ($urandom_range(0, 99) < 2), 1'b0);
        drive(~d, 1'b0, 1'b0);
      end
    end

    // Drain with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/manchester_link_ctrl.md
Name: manchester_link_ctrl

Overview:
- Line-sync controller that sits ahead of the Manchester-to-NRZ-to-PAM4 converter chain.
- Samples the raw Manchester stream at one sample per half-bit and hunts for half-bit phase alignment by slipping on invalid pairs (00/11).
- Declares and maintains lock, then drives the converter's enable and sync pulse, plus NRZ/PAM4 symbol strobes.
- Counts code violations for link-quality monitoring.

Parameters:
LOCK_PAIRS, 8, consecutive valid Manchester pairs required in HUNT to declare lock (range 1..255)
LOSS_PAIRS, 3, consecutive invalid pairs in LOCKED that force return to HUNT (range 1..255)
ERR_W, 8, width of saturating violation counter

Ports:
clock  input  1  sample clock, one Manchester half-bit per rising edge
reset  input  1  asynchronous, active-high reset
manchester_in  input  1  raw Manchester serial sample
err_clr  input  1  synchronous clear of err_count
locked  output  1  high while in LOCKED state
conv_enable  output  1  enable to converter datapath; equals locked
dp_sync  output  1  one-cycle pulse on lock entry; converter resets its FSM to idle so the next sample is a first half-bit
half_phase  output  1  1 when the next sample is a second half-bit (internal half register, exported)
nrz_strobe  output  1  one-cycle pulse per completed Manchester pair while LOCKED
pam_strobe  output  1  one-cycle pulse on every second nrz_strobe (PAM4 symbol boundary)
code_err  output  1  one-cycle pulse coincident with nrz_strobe when that pair was invalid
err_count  output  ERR_W  saturating count of invalid pairs seen while LOCKED

Behaviour:
- Reset (async): state=HUNT, half=0, prev=0, good_cnt=0, bad_run=0, sym=0; all outputs 0, err_count=0.
- Every output is registered and reflects the decision made at the preceding clock edge.
- Pair formation:
  - Edge with half=0: prev<=manchester_in, half<=1.
  - Edge with half=1: evaluates pair (prev, manchester_in); valid = prev XOR manchester_in; NRZ value = prev (10->1, 01->0).
- HUNT:
  - Valid pair: good_cnt++, half<=0.
  - Invalid pair: slip. prev<=manchester_in, half stays 1 (current sample becomes a new first half), good_cnt<=0.
  - Valid pair bringing good_cnt to LOCK_PAIRS: go to LOCKED at that edge; locked/conv_enable<=1; dp_sync<=1 for one cycle; sym<=0; bad_run<=0.
  - The lock-entry pair does not produce nrz_strobe.
  - No strobes or code_err while in HUNT; err_count is held.
- LOCKED:
  - No slipping; half toggles every edge.
  - Every pair evaluation: nrz_strobe<=1; pam_strobe<=sym; sym toggles.
  - Invalid pairs count as symbols so PAM4 alignment is kept.
  - Invalid pair: code_err<=1; err_count++ (saturates at 2^ERR_W-1); bad_run++.
  - Valid pair: bad_run<=0.
  - Invalid pair bringing bad_run to LOSS_PAIRS: that pair still strobes and counts; state<=HUNT; locked/conv_enable<=0 at the same edge; good_cnt<=0; half<=0.
- err_clr: synchronous. If err_clr coincides with a violation, clear wins and err_count=0.
- Steady lock timing: nrz_strobe every 2 cycles, pam_strobe every 4 cycles, both aligned to second-half sample edges.
- First nrz_strobe comes 2 cycles after dp_sync; first pam_strobe comes with the second nrz_strobe.
- Reset mid-lock: immediate return to reset values. No pending strobe completes.
- good_cnt and bad_run are 8-bit and saturate. They never wrap.

Test Plan:
1. Reset check: hold reset with manchester_in toggling -> all outputs 0, err_count=0, half_phase=0 throughout.
2. Aligned lock: from reset, drive 8 valid pairs 10,01,10,01... -> at edge 16, locked=1 and dp_sync pulses for one cycle; first nrz_strobe at edge 18; pam_strobe at edges 20, 24, 28...
3. Misaligned start: drive 0,0 then 8 valid pairs (1,0... pattern starting 1) -> slip at edge 2, pairs complete at edges 3,5,...,17, locked=1 at edge 17, no strobes before lock.
4. Single violation in lock: insert one 11 pair -> code_err and nrz_strobe together, err_count=1, locked stays 1, pam_strobe cadence unchanged.
5. Loss of lock: 3 consecutive 00 pairs -> code_err on each, err_count +3, locked and conv_enable drop at the third pair's edge, relock after 8 valid pairs.
6. Saturation and clear: ERR_W=2, alternating bad/good pairs while locked -> err_count sticks at 3; err_clr coinciding with a violation -> err_count=0. Assert reset mid-lock -> all outputs 0 immediately.
